ternary_dot_sequencer: RTL
==========================

# ternary_dot_sequencer

Control block that sequences the ternary dot-product datapath across a multi-chunk vector. It issues chunk indices to the datapath and accumulates the signed partial sums it returns into a saturating 16-bit result. It presents that result through a valid/ready handshake to the output mux that drives the 16-bit result bus. The block sits between the host-side command decode and the ternary dot datapath, and it owns the vector loop.

## Interface
Parameters:
- `CHUNKS`, 8: maximum chunks per vector.
- `PSUM_W`, 14: width of the signed partial sum returned per chunk.
- `ACC_W`, 16: width of the signed result.

Ports:
- `clk`  in  1  Single clock; all logic is on the rising edge.
- `rst`  in  1  Reset, synchronous and active-high.
- `start`  in  1  Begin a vector. Sampled only in IDLE.
- `len`  in  $clog2(CHUNKS)+1  Number of chunks, sampled with `start`. Values above `CHUNKS` clamp to `CHUNKS`.
- `busy`  out  1  High in every state except IDLE.
- `dp_en`  out  1  Chunk request to the datapath.
- `dp_addr`  out  $clog2(CHUNKS)  Chunk index, valid while `dp_en` is high.
- `psum`  in  PSUM_W  Signed partial sum from the datapath.
- `psum_valid`  in  1  `psum` is valid this cycle.
- `res`  out  ACC_W  Signed accumulated result.
- `res_valid`  out  1  `res` is valid.
- `res_ready`  in  1  Consumer accepts `res`.
- `sat`  out  1  Sticky saturation flag for the current vector. Valid alongside `res`.

## Operation
- There are four states: IDLE, ISSUE, DRAIN, DONE.
- **IDLE:**
  - If `start` is high and effective `len` is nonzero: latch `len`, clear the accumulator, `sat`, the issue count and the receive count, then go to ISSUE.
  - If `start` is high and `len` is 0: clear the accumulator and `sat`, then go to DONE. `res` is 0 and `dp_en` is never asserted.
- **ISSUE:**
  - `dp_en` is 1 and `dp_addr` equals the issue count.
  - The issue count increments every cycle. `dp_en` stays high for exactly `len` consecutive cycles with `dp_addr` = 0..len-1.
  - After the last issue, go to DRAIN. If the final psum has already been received, go directly to DONE.
- **DRAIN:** `dp_en` is 0. Wait until the receive count equals `len`, then go to DONE.
- **Accumulation** (ISSUE and DRAIN only):
  - On each `psum_valid`, compute acc <= clamp(acc + sign_extend(psum)) to the range [-32768, 32767], then increment the receive count.
  - Clamping is applied at every step, not once at the end.
  - If a step clamps, `sat` is set and stays set until the next vector starts.
- **Ignored `psum_valid`:** pulses in IDLE or DONE are ignored. Pulses after the receive count reaches `len` are ignored.
- **DONE:**
  - `res_valid` is 1. `res` and `sat` are held stable.
  - On `res_ready` = 1, go to IDLE.
  - `start` is ignored while `busy` is high.
- **Reset:** on `rst`, the state returns to IDLE, the counters and accumulator clear, and all outputs go to 0 (`busy`, `dp_en`, `dp_addr`, `res`, `res_valid`, `sat`). Reset takes priority over every other event, including mid-vector.

## Timing
- Let `start` be sampled at the edge ending cycle t.
- ISSUE occupies cycles t+1 .. t+len. `dp_en` is high in exactly those cycles.
- Datapath latency is not fixed. Completion is driven by `psum_valid` counting, so gaps and variable latency are tolerated.
- The accumulator updates on the same edge that samples `psum_valid`.
- `res_valid` rises in the cycle after the edge that samples the final psum. With a datapath latency of 1, psums arrive in cycles t+2..t+len+1 and `res_valid` is high from cycle t+len+2.
- With `len` = 0, `res_valid` is high in cycle t+1.
- The handshake completes on the edge where `res_valid` and `res_ready` are both high. `res_valid` is low in the next cycle, which is IDLE.
- The earliest accepted next `start` is in that IDLE cycle.
- `busy` is registered and is high from cycle t+1 through the handshake cycle.

## Test plan
- **Basic sequence:** `len`=4, latency 1, psums 10, -3, 7, 1.
  - `dp_addr` = 0, 1, 2, 3 in cycles t+1..t+4.
  - `res` = 15 and `sat` = 0, with `res_valid` high at t+6.
- **Saturation (positive and stepwise clamp):**
  - `len`=8, all psums 8191 → `res` = 32767, `sat` = 1.
  - `len`=6, psums 8191 ×5 then -8192 → `res` = 24575, `sat` = 1. A wide, end-clamped accumulator would give 32763 instead, so this case checks per-step clamping.
- **Saturation (negative):** `len`=5, all psums -8192 → `res` = -32768, `sat` = 1.
- **Zero length:** `len`=0 → `dp_en` never high, `res` = 0, `res_valid` at t+1. A `len`=12 request with `CHUNKS`=8 issues exactly 8 chunks.
- **Backpressure and variable latency:**
  - Hold `res_ready` = 0 for 5 cycles: `res` and `sat` stay stable and `start` pulses are ignored.
  - Inject psums with latency 3 and gaps: the result is identical to the latency-1 run.
  - Stray `psum_valid` in IDLE and DONE has no effect.
- **Reset mid-vector:** assert `rst` while `dp_addr` = 2.
  - All outputs are 0 in the next cycle, and later `psum_valid` pulses are ignored.
  - A fresh `start` with `len`=2 and psums 5, 6 yields `res` = 11.

Source files
------------

// File: rtl/ternary_dot_sequencer.sv
// Vector-loop sequencer for the ternary dot datapath: issues chunk indices, accumulates
// returned partial sums with per-step saturation, and holds the result until res_ready.
module ternary_dot_sequencer #(
   parameter int CHUNKS = 8,
   parameter int PSUM_W = 14,
   parameter int ACC_W  = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [$clog2(CHUNKS):0]   len,
   output logic                      busy,
   output logic                      dp_en,
   output logic [$clog2(CHUNKS)-1:0] dp_addr,
   input  logic [PSUM_W-1:0]         psum,
   input  logic                      psum_valid,
   output logic [ACC_W-1:0]          res,
   output logic                      res_valid,
   input  logic                      res_ready,
   output logic                      sat
);

   localparam int LEN_W  = $clog2(CHUNKS) + 1;
   localparam int ADDR_W = $clog2(CHUNKS);

   localparam logic [ACC_W-1:0] ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};
   localparam logic [LEN_W-1:0] CHUNKS_L = LEN_W'(CHUNKS);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic [LEN_W-1:0]   issue_cnt_q, issue_cnt_d;
   logic [LEN_W-1:0]   rcv_cnt_q, rcv_cnt_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic               sat_q, sat_d;
   logic               busy_q, busy_d;

   logic [LEN_W-1:0]   len_eff;
   logic [ACC_W:0]     sum;
   logic               take;

   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      issue_cnt_d = issue_cnt_q;
      rcv_cnt_d   = rcv_cnt_q;
      acc_d       = acc_q;
      sat_d       = sat_q;

      len_eff = (len > CHUNKS_L) ? CHUNKS_L : len;

      // One guard bit is enough: both operands fit ACC_W, so overflow shows as a
      // disagreement between the top two bits of the sum.
      sum  = {acc_q[ACC_W-1], acc_q} + {{(ACC_W+1-PSUM_W){psum[PSUM_W-1]}}, psum};
      take = ((state_q == S_ISSUE) || (state_q == S_DRAIN)) && psum_valid
             && (rcv_cnt_q != len_q);

      if (take) begin
         rcv_cnt_d = rcv_cnt_q + 1'b1;
         if (sum[ACC_W] != sum[ACC_W-1]) begin
            acc_d = sum[ACC_W] ? ACC_MIN : ACC_MAX;
            sat_d = 1'b1;
         end else begin
            acc_d = sum[ACC_W-1:0];
         end
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               acc_d       = '0;
               sat_d       = 1'b0;
               issue_cnt_d = '0;
               rcv_cnt_d   = '0;
               len_d       = len_eff;
               state_d     = (len_eff == '0) ? S_DONE : S_ISSUE;
            end
         end
         S_ISSUE: begin
            issue_cnt_d = issue_cnt_q + 1'b1;
            if (issue_cnt_d == len_q) begin
               state_d = (rcv_cnt_d == len_q) ? S_DONE : S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (rcv_cnt_d == len_q) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (res_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         len_q       <= '0;
         issue_cnt_q <= '0;
         rcv_cnt_q   <= '0;
         acc_q       <= '0;
         sat_q       <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         issue_cnt_q <= issue_cnt_d;
         rcv_cnt_q   <= rcv_cnt_d;
         acc_q       <= acc_d;
         sat_q       <= sat_d;
         busy_q      <= busy_d;
      end
   end

   assign busy      = busy_q;
   assign dp_en     = (state_q == S_ISSUE);
   assign dp_addr   = dp_en ? issue_cnt_q[ADDR_W-1:0] : '0;
   assign res       = acc_q;
   assign res_valid = (state_q == S_DONE);
   assign sat       = sat_q;

endmodule
